lfsr_seq_gen: RTL and testbench
===============================

// Module: lfsr_seq_gen
// PURPOSE
//  Parametrised pseudo-random symbol-sequence generator for the memory game.
//  A WIDTH-bit Fibonacci LFSR, seeded on request, fills a DEPTH-entry symbol buffer.
//  The buffer can grow by one symbol per round and can be replayed to the display/compare logic.
//  The replay side uses a valid/ready stream. Never locks up in the all-zero state.
// PARAMETERS
//  WIDTH  8      LFSR register width (>= SYM_W, >= 3)
//  TAPS   8'hB8  feedback tap mask, bit i set = q[i] in XOR
//  SYM_W  2      symbol width (symbol = q[SYM_W-1:0])
//  DEPTH  16     max stored sequence length
//  LEN_W  5      length counter width, $clog2(DEPTH+1)
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-high
//  seed_load     in   1      load seed into LFSR (IDLE only)
//  seed          in   WIDTH  seed value; 0 is replaced by 1
//  gen_start     in   1      clear buffer, generate gen_len new symbols
//  gen_len       in   LEN_W  symbols to generate; 0 = ignore; >DEPTH clamps to DEPTH
//  append        in   1      generate one more symbol at end of buffer
//  replay_start  in   1      stream stored sequence out
//  sym_ready     in   1      consumer accepts sym
//  sym_valid     out  1      sym/sym_last valid
//  sym           out  SYM_W  replayed symbol
//  sym_last      out  1      sym is final stored symbol
//  seq_len       out  LEN_W  current stored length
//  busy          out  1      state != IDLE
//  done          out  1      1-cycle pulse: generate/append/replay finished
//  overflow      out  1      1-cycle pulse: append refused, buffer full
//  lfsr_q        out  WIDTH  current LFSR state (debug/other randomness)
// BEHAVIOUR
//  Reset (async): lfsr_q=1, seq_len=0, state=IDLE; all other outputs 0.
//  Buffer contents are don't-care after reset.
//  LFSR step: q <= {q[WIDTH-2:0], ^(q & TAPS)}.
//   - In IDLE, q steps every cycle: free-run; user timing is the entropy.
//   - In GEN, q steps once per symbol written.
//  States: IDLE, GEN, REPLAY.
//  IDLE command priority: seed_load > gen_start > append > replay_start.
//   - Only one command is taken per cycle. All commands are ignored while busy.
//  seed_load: q <= (seed==0) ? 1 : seed. No step that cycle. No done pulse.
//  gen_start, gen_len!=0: seq_len <= 0, target = min(gen_len, DEPTH), enter GEN.
//  GEN: each cycle, write buf[seq_len] <= q[SYM_W-1:0], step q, seq_len++.
//   - Leave GEN when seq_len reaches target. done pulses on the cycle after the last write.
//   - N symbols take exactly N cycles in GEN.
//  append with seq_len<DEPTH: enter GEN with target = seq_len+1. Existing symbols are kept.
//  append with seq_len==DEPTH: stay in IDLE, pulse overflow. Buffer and q are unchanged.
//  replay_start with seq_len==0: ignored, no done pulse.
//  replay_start with seq_len>0: enter REPLAY, rd_ptr=0.
//   - sym_valid rises the next cycle with sym = buf[0].
//  REPLAY is a standard valid/ready stream:
//   - sym/sym_last are held stable while valid && !ready.
//   - One symbol is consumed per cycle where valid && ready.
//   - Back-to-back symbols are sustained at full rate.
//   - sym_last = (rd_ptr == seq_len-1).
//   - On the last handshake: sym_valid drops, go to IDLE, pulse done in the same cycle as the drop.
//   - Replay does not modify the buffer or seq_len. The LFSR holds during REPLAY.
//  Reset asserted mid-GEN/REPLAY aborts immediately to the reset values.
// STRUCTURE
//  Package lfsr_seq_pkg holds:
//   - state enum {IDLE, GEN, REPLAY};
//   - the default TAPS masks for WIDTH 4/8/16 (4'h9, 8'hB8, 16'hB400);
//   - a function lfsr_next(q, taps).
//  Sub-module lfsr_core(WIDTH, TAPS) contains the register plus step/load/zero-guard.
//   - It has no knowledge of symbols.
//  Top level holds the FSM, buffer (register array, 1 write / 1 read port), counters and the output register.
// TESTING
//  Reset: lfsr_q=8'h01, seq_len=0, busy=0, sym_valid=0.
//  seed_load seed=8'h00: lfsr_q=8'h01.
//  seed_load seed=8'h01, next cycle gen_start gen_len=4:
//   - 4 GEN cycles, q steps 01,02,04,08 -> 11;
//   - buffer = {1,2,0,0}; done 1 cycle after the last write; seq_len=4.
//  Replay with sym_ready tied 1:
//   - sym = 1,2,0,0 on 4 consecutive cycles;
//   - sym_last only on the 4th; done with the valid drop.
//  Replay with sym_ready toggling 1-0-1-0: each symbol is held across ready=0 cycles, and no symbol is lost or duplicated.
//  append x12 after gen_len=4: seq_len reaches 16.
//   - The 13th append pulses overflow.
//   - seq_len stays 16, and the first 4 symbols are unchanged.
//  Reset asserted during the 3rd GEN cycle of gen_len=8: the next cycle shows the reset values, and a following replay_start is ignored.

Source files
------------

// File: rtl/lfsr_seq_pkg.sv
// Shared types and helpers for the LFSR symbol-sequence generator.
package lfsr_seq_pkg;

  typedef enum logic [1:0] {StIdle, StGen, StReplay} state_e;

  localparam logic [3:0]  TAPS_W4  = 4'h9;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  // Fibonacci shift-left step; callers truncate to their own register width.
  function automatic logic [31:0] lfsr_next(input logic [31:0] q, input logic [31:0] taps);
    return {q[30:0], ^(q & taps)};
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR register with load and step; never holds the all-zero lock-up state.
module lfsr_core
  import lfsr_seq_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_next;

  assign q_next = WIDTH'(lfsr_next(32'(q), 32'(TAPS)));

  // Zero on either path is replaced by 1 so the sequence can never stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= WIDTH'(1);
    end else if (load) begin
      q <= (load_val == '0) ? WIDTH'(1) : load_val;
    end else if (step) begin
      q <= (q_next == '0) ? WIDTH'(1) : q_next;
    end
  end

endmodule

// File: rtl/lfsr_seq_gen.sv
// Memory-game symbol generator: LFSR-filled buffer with append and valid/ready replay.
module lfsr_seq_gen
  import lfsr_seq_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W8,
  parameter int unsigned      SYM_W = 2,
  parameter int unsigned      DEPTH = 16,
  parameter int unsigned      LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             gen_start,
  input  logic [LEN_W-1:0] gen_len,
  input  logic             append,
  input  logic             replay_start,
  input  logic             sym_ready,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym,
  output logic             sym_last,
  output logic [LEN_W-1:0] seq_len,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [WIDTH-1:0] lfsr_q
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           state_q;
  logic [LEN_W-1:0] seq_len_q, target_q, rd_ptr_q;
  logic             sym_valid_q, sym_last_q, done_q, overflow_q;
  logic [SYM_W-1:0] sym_q;
  logic [SYM_W-1:0] sym_buf [DEPTH];

  logic             seed_take, gen_take, app_take, rep_take, lfsr_step, full;
  logic [LEN_W-1:0] gen_target, seq_len_inc, rd_ptr_inc;

  always_comb begin
    seed_take   = (state_q == StIdle) && seed_load;
    gen_take    = (state_q == StIdle) && !seed_load && gen_start && (gen_len != '0);
    app_take    = (state_q == StIdle) && !seed_load && !gen_start && append;
    rep_take    = (state_q == StIdle) && !seed_load && !gen_start && !append &&
                  replay_start && (seq_len_q != '0);
    // Idle free-run pauses on any cycle a command is accepted (incl. refused append).
    lfsr_step   = (state_q == StGen) ||
                  ((state_q == StIdle) && !(seed_take || gen_take || app_take || rep_take));
    gen_target  = (gen_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : gen_len;
    seq_len_inc = seq_len_q + 1'b1;
    rd_ptr_inc  = rd_ptr_q + 1'b1;
    full        = (seq_len_q == LEN_W'(DEPTH));
  end

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr_core (
    .clk      (clk),
    .reset    (reset),
    .step     (lfsr_step),
    .load     (seed_take),
    .load_val (seed),
    .q        (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (state_q == StGen) begin
      sym_buf[seq_len_q[IDX_W-1:0]] <= lfsr_q[SYM_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      seq_len_q   <= '0;
      target_q    <= '0;
      rd_ptr_q    <= '0;
      sym_valid_q <= 1'b0;
      sym_q       <= '0;
      sym_last_q  <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gen_take) begin
            seq_len_q <= '0;
            target_q  <= gen_target;
            state_q   <= StGen;
          end else if (app_take) begin
            if (full) begin
              overflow_q <= 1'b1;
            end else begin
              target_q <= seq_len_inc;
              state_q  <= StGen;
            end
          end else if (rep_take) begin
            rd_ptr_q    <= '0;
            sym_q       <= sym_buf[0];
            sym_last_q  <= (seq_len_q == LEN_W'(1));
            sym_valid_q <= 1'b1;
            state_q     <= StReplay;
          end
        end
        StGen: begin
          seq_len_q <= seq_len_inc;
          if (seq_len_inc == target_q) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        StReplay: begin
          if (sym_valid_q && sym_ready) begin
            if (sym_last_q) begin
              sym_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StIdle;
            end else begin
              rd_ptr_q   <= rd_ptr_inc;
              sym_q      <= sym_buf[rd_ptr_inc[IDX_W-1:0]];
              sym_last_q <= (rd_ptr_inc == seq_len_q - 1'b1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym       = sym_q;
  assign sym_last  = sym_last_q;
  assign seq_len   = seq_len_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Bench for lfsr_seq_gen: directed scenarios plus random commands against a queue-based model.
module tb_lfsr_seq_gen;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       seed_load, gen_start, append, replay_start, sym_ready;
  logic [7:0] seed;
  logic [4:0] gen_len;
  logic       sym_valid, sym_last, busy, done, overflow;
  logic [1:0] sym;
  logic [4:0] seq_len;
  logic [7:0] lfsr_q;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model: symbol list as a queue, modes as plain ints.
  logic [7:0] m_q;
  logic [1:0] m_seq[$];
  int         m_mode;  // 0 idle, 1 generating, 2 replaying
  int         m_left;
  int         m_rd;
  bit         m_done, m_ovf;

  logic [1:0] exp4 [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
  logic [1:0] got[$];

  lfsr_seq_gen u_dut (
    .clk          (clk),
    .reset        (reset),
    .seed_load    (seed_load),
    .seed         (seed),
    .gen_start    (gen_start),
    .gen_len      (gen_len),
    .append       (append),
    .replay_start (replay_start),
    .sym_ready    (sym_ready),
    .sym_valid    (sym_valid),
    .sym          (sym),
    .sym_last     (sym_last),
    .seq_len      (seq_len),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .lfsr_q       (lfsr_q)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_total++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] spec_step(input logic [7:0] q);
    return {q[6:0], ^(q & 8'hB8)};
  endfunction

  task automatic model_reset();
    m_q = 8'h01;
    m_seq.delete();
    m_mode = 0;
    m_left = 0;
    m_rd   = 0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    m_ovf  = 1'b0;
    case (m_mode)
      0: begin
        if (seed_load) begin
          m_q = (seed == 8'h00) ? 8'h01 : seed;
        end else if (gen_start && gen_len != 0) begin
          m_seq.delete();
          m_left = (gen_len > DEPTH) ? DEPTH : int'(gen_len);
          m_mode = 1;
        end else if (!gen_start && append) begin
          if (m_seq.size() == DEPTH) m_ovf = 1'b1;
          else begin
            m_left = 1;
            m_mode = 1;
          end
        end else if (!gen_start && !append && replay_start && m_seq.size() > 0) begin
          m_mode = 2;
          m_rd   = 0;
        end else begin
          m_q = spec_step(m_q);
        end
      end
      1: begin
        m_seq.push_back(m_q[1:0]);
        m_q = spec_step(m_q);
        m_left--;
        if (m_left == 0) begin
          m_mode = 0;
          m_done = 1'b1;
        end
      end
      default: begin
        if (sym_ready) begin
          m_rd++;
          if (m_rd == m_seq.size()) begin
            m_mode = 0;
            m_done = 1'b1;
            m_rd   = 0;
          end
        end
      end
    endcase
  endtask

  task automatic cmp_model();
    check_eq("lfsr_q", 32'(lfsr_q), 32'(m_q));
    check_eq("seq_len", 32'(seq_len), m_seq.size());
    check_eq("busy", 32'(busy), 32'(m_mode != 0));
    check_eq("sym_valid", 32'(sym_valid), 32'(m_mode == 2));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    if (m_mode == 2) begin
      check_eq("sym", 32'(sym), 32'(m_seq[m_rd]));
      check_eq("sym_last", 32'(sym_last), 32'(m_rd == m_seq.size() - 1));
    end
  endtask

  // One clock: model advances with the same inputs, DUT is compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic clear_inputs();
    seed_load    = 1'b0;
    gen_start    = 1'b0;
    append       = 1'b0;
    replay_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      cycle();
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic replay_collect(input bit toggle_ready);
    int n = 0;
    got.delete();
    replay_start = 1'b1;
    sym_ready    = 1'b1;
    cycle();
    replay_start = 1'b0;
    while (busy && n < 64) begin
      sym_ready = toggle_ready ? (n % 2 == 0) : 1'b1;
      if (sym_valid && sym_ready) got.push_back(sym);
      cycle();
      n++;
    end
    check_eq("replay_end", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    seed      = 8'h00;
    gen_len   = 5'd0;
    sym_ready = 1'b0;
    model_reset();
    cycle();
    cycle();
    check_eq("rst_lfsr", 32'(lfsr_q), 32'h01);
    check_eq("rst_len", 32'(seq_len), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(sym_valid), 32'd0);
    reset = 1'b0;

    // Zero seed is replaced by 1
    seed_load = 1'b1;
    seed      = 8'h00;
    cycle();
    check_eq("seed0", 32'(lfsr_q), 32'h01);

    seed = 8'h01;
    cycle();
    seed_load = 1'b0;
    gen_start = 1'b1;
    gen_len   = 5'd4;
    cycle();
    gen_start = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("gen4_busy", 32'(busy), 32'd1);
    cycle();
    check_eq("gen4_done", 32'(done), 32'd1);
    check_eq("gen4_len", 32'(seq_len), 32'd4);
    check_eq("gen4_lfsr", 32'(lfsr_q), 32'h11);

    // Full-rate replay
    replay_start = 1'b1;
    sym_ready    = 1'b1;
    cycle();
    replay_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("rep_sym", 32'(sym), 32'(exp4[i]));
      check_eq("rep_last", 32'(sym_last), 32'(i == 3));
      cycle();
    end
    check_eq("rep_drop", 32'(sym_valid), 32'd0);
    check_eq("rep_done", 32'(done), 32'd1);

    // Throttled replay
    replay_collect(1'b1);
    check_eq("tog_count", got.size(), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) check_eq("tog_sym", 32'(got[i]), 32'(exp4[i]));

    // Fill to DEPTH with appends, then one too many
    for (int k = 0; k < 12; k++) begin
      append = 1'b1;
      cycle();
      append = 1'b0;
      wait_idle("append_wait", 4);
    end
    check_eq("fill_len", 32'(seq_len), 32'd16);
    append = 1'b1;
    cycle();
    append = 1'b0;
    check_eq("ovf_pulse", 32'(overflow), 32'd1);
    check_eq("ovf_len", 32'(seq_len), 32'd16);
    replay_collect(1'b0);
    check_eq("full_count", got.size(), 32'd16);
    for (int i = 0; i < 4 && i < got.size(); i++) check_eq("kept_sym", 32'(got[i]), 32'(exp4[i]));

    // Reset during the third generate cycle
    gen_start = 1'b1;
    gen_len   = 5'd8;
    cycle();
    gen_start = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    check_eq("abort_lfsr", 32'(lfsr_q), 32'h01);
    check_eq("abort_len", 32'(seq_len), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    reset        = 1'b0;
    replay_start = 1'b1;
    cycle();
    replay_start = 1'b0;
    check_eq("abort_rep", 32'(sym_valid), 32'd0);
    check_eq("abort_rep_busy", 32'(busy), 32'd0);

    // Random commands, including while busy
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 999) < 4);
      seed_load    = ($urandom_range(0, 99) < 4);
      seed         = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      gen_start    = ($urandom_range(0, 99) < 5);
      gen_len      = 5'($urandom_range(1, 31));
      append       = ($urandom_range(0, 99) < 12);
      replay_start = ($urandom_range(0, 99) < 12);
      sym_ready    = ($urandom_range(0, 99) < 65);
      cycle();
    end
    reset = 1'b0;
    clear_inputs();
    sym_ready = 1'b1;
    cycle();
    wait_idle("final_idle", 40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
